// File: rtl/irq_controller.sv
// Interrupt aggregator: per-source edge latch or level pass-through, mask, one registered irq.
// Define IRQ_CAUSE_EN to add the CAUSE priority encoder with auto-clear on read.
module irq_controller #(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] EDGE_RESET = 32'h0
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic               select,
    input  logic [3:0]         we,
    input  logic               rd,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq
);

    logic [NUM_SRC-1:0] enable_q, pending_q, edge_q, src_prev_q;
    logic [NUM_SRC-1:0] wmask, wbits, w1c, active, cause_clr, pend_nx;
    logic [31:0]        cause;
    logic               wr, irq_q;

    assign wr     = select && (we != 4'b0000);
    assign active = pending_q & enable_q;
    assign irq    = irq_q;

    always_comb begin
        wmask = '0;
        wbits = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            wmask[i] = we[i/8];
            wbits[i] = wdata[i];
        end
    end

    assign w1c = (wr && addr == 3'd2) ? (wbits & wmask) : '0;

`ifdef IRQ_CAUSE_EN
    logic [4:0]         cause_idx;
    logic [NUM_SRC-1:0] cause_oh;

    // Scan high to low so the lowest-numbered active source wins.
    always_comb begin
        cause_idx = '0;
        cause_oh  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                cause_idx   = 5'(i);
                cause_oh    = '0;
                cause_oh[i] = 1'b1;
            end
        end
        cause     = {|active, 26'b0, cause_idx};
        cause_clr = (select && rd && addr == 3'd4) ? (cause_oh & edge_q) : '0;
    end
`else
    assign cause     = '0;
    assign cause_clr = '0;
`endif

    wire unused_ok = &{1'b0, rd, wdata};

    // A new rising edge is OR'd in after the clears, so set beats clear.
    always_comb begin
        pend_nx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_q[i])
                pend_nx[i] = (src[i] & ~src_prev_q[i]) |
                             (pending_q[i] & ~w1c[i] & ~cause_clr[i]);
            else
                pend_nx[i] = src[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            enable_q   <= '0;
            pending_q  <= '0;
            edge_q     <= EDGE_RESET[NUM_SRC-1:0];
            src_prev_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            src_prev_q <= src;
            pending_q  <= pend_nx;
            irq_q      <= |active;
            if (wr && addr == 3'd1)
                enable_q <= (enable_q & ~wmask) | (wbits & wmask);
            if (wr && addr == 3'd3)
                edge_q <= (edge_q & ~wmask) | (wbits & wmask);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            3'd0:    rdata[NUM_SRC-1:0] = src;
            3'd1:    rdata[NUM_SRC-1:0] = enable_q;
            3'd2:    rdata[NUM_SRC-1:0] = pending_q;
            3'd3:    rdata[NUM_SRC-1:0] = edge_q;
            3'd4:    rdata = cause;
            default: rdata = '0;
        endcase
    end

endmodule
